// File: rtl/flatten_4ch_serializer.sv
// Captures 4-channel pooled pixels into a FIFO and replays them as one serial stream (pixel-major, channel-minor).
// Optional sticky overflow flag: define FLATTEN4_OVERFLOW_FLAG_EN.
//
// state | meaning
// IDLE  | nothing presented, waiting for a FIFO entry
// SEND  | Out/out_ch/out_idx/out_last presented, waiting for out_ready
module flatten_4ch_serializer #(
    parameter int Datawidth = 16,
    parameter int Depth     = 4,
    parameter int Pixels    = 1,
    parameter int IdxWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [Datawidth-1:0] In_0,
    input  logic [Datawidth-1:0] In_1,
    input  logic [Datawidth-1:0] In_2,
    input  logic [Datawidth-1:0] In_3,
    output logic                 in_full,
    output logic                 ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Datawidth-1:0] Out,
    output logic [1:0]           out_ch,
    output logic [IdxWidth-1:0]  out_idx,
    output logic                 out_last
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam int PW = (Pixels > 1) ? $clog2(Pixels) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state, state_next;
    logic [3:0][Datawidth-1:0]   mem [Depth];
    logic [3:0][Datawidth-1:0]   in_word, head;
    logic [Datawidth-1:0]        next_head0;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic [CW-1:0]               count, count_next;
    logic                        full_q;
    logic [1:0]                  ch, ch_next;
    logic [PW-1:0]               pix, pix_next;
    logic [Datawidth-1:0]        out_q, out_next;
    logic [IdxWidth-1:0]         idx_q, idx_next;
    logic                        last_q, last_next;
    logic                        handshake, pop, wr_en;

    assign in_word    = {In_3, In_2, In_1, In_0};
    assign handshake  = (state == SEND) && out_ready;
    assign pop        = handshake && (ch == 2'd3);
    assign wr_en      = valid_in && ((count < CW'(Depth)) || pop);
    assign count_next = count - CW'(pop) + CW'(wr_en);
    assign head       = mem[rd_ptr];
    // With a single entry being popped, the next head is the word written this same edge.
    assign next_head0 = (count == CW'(1)) ? In_0 : mem[rd_ptr + AW'(1)][0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            full_q <= (count_next == CW'(Depth));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= 2'd0;
            pix    <= '0;
            out_q  <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_next;
            ch     <= ch_next;
            pix    <= pix_next;
            out_q  <= out_next;
            idx_q  <= idx_next;
            last_q <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        ch_next    = ch;
        pix_next   = pix;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = SEND;
                    ch_next    = 2'd0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (ch != 2'd3) begin
                        ch_next = ch + 2'd1;
                    end else begin
                        ch_next  = 2'd0;
                        pix_next = (pix == PW'(Pixels - 1)) ? '0 : pix + PW'(1);
                        if (count_next == '0) state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_next = out_q;
        if ((state == IDLE) && (count != '0)) begin
            out_next = head[0];
        end else if (handshake) begin
            if (ch != 2'd3)               out_next = head[ch + 2'd1];
            else if (count_next != '0)    out_next = next_head0;
        end
        idx_next  = IdxWidth'({pix_next, ch_next});
        last_next = (state_next == SEND) && (pix_next == PW'(Pixels - 1)) && (ch_next == 2'd3);
    end

    assign out_valid = (state == SEND);
    assign Out       = out_q;
    assign out_ch    = ch;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign in_full   = full_q;

`ifdef FLATTEN4_OVERFLOW_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        ovf_q <= 1'b0;
        else if (valid_in && !wr_en)    ovf_q <= 1'b1;
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_flatten_4ch_serializer.sv
// Scoreboard bench for flatten_4ch_serializer: one instance with Pixels=1 and one with Pixels=2 share stimulus.
module tb_flatten_4ch_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] in0, in1, in2, in3;
    logic        out_ready;

    logic        full1, ovf1, v1, last1;
    logic [15:0] o1;
    logic [1:0]  ch1;
    logic [7:0]  idx1;
    logic        full2, ovf2, v2, last2;
    logic [15:0] o2;
    logic [1:0]  ch2;
    logic [7:0]  idx2;

`ifdef FLATTEN4_OVERFLOW_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    flatten_4ch_serializer #(.Datawidth(16), .Depth(4), .Pixels(1), .IdxWidth(8)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
        .in_full(full1), .ovf(ovf1), .out_valid(v1), .out_ready(out_ready),
        .Out(o1), .out_ch(ch1), .out_idx(idx1), .out_last(last1)
    );

    flatten_4ch_serializer #(.Datawidth(16), .Depth(4), .Pixels(2), .IdxWidth(8)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .In_0(in0), .In_1(in1), .In_2(in2), .In_3(in3),
        .in_full(full2), .ovf(ovf2), .out_valid(v2), .out_ready(out_ready),
        .Out(o2), .out_ch(ch2), .out_idx(idx2), .out_last(last2)
    );

    typedef struct {
        logic [15:0] data;
        logic [1:0]  ch;
        logic [7:0]  idx1;
        logic        last1;
        logic [7:0]  idx2;
        logic        last2;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;
    int   pix2     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pixel(input logic [15:0] a, b, c, d);
        logic [15:0] vals [4];
        exp_t x;
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        for (int k = 0; k < 4; k++) begin
            x.data  = vals[k];
            x.ch    = 2'(k);
            x.idx1  = 8'(k);
            x.last1 = (k == 3);
            x.idx2  = 8'(pix2 * 4 + k);
            x.last2 = (pix2 == 1) && (k == 3);
            q.push_back(x);
        end
        pix2 = (pix2 + 1) % 2;
    endtask

    task automatic strobe(input logic [15:0] a, b, c, d, input bit accept);
        in0 = a; in1 = b; in2 = c; in3 = d;
        valid_in = 1'b1;
        if (accept) push_pixel(a, b, c, d);
        tick();
        valid_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        pix2 = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q.size() != 0 || v1) && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_queue"}, q.size(), 0);
        chk({name, "_valid"}, v1, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && v1 && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=none", o1);
            end else begin
                e = q.pop_front();
                chk("out_data1", o1, e.data);
                chk("out_data2", o2, e.data);
                chk("out_ch1", ch1, e.ch);
                chk("out_ch2", ch2, e.ch);
                chk("out_idx1", idx1, e.idx1);
                chk("out_last1", last1, e.last1);
                chk("out_idx2", idx2, e.idx2);
                chk("out_last2", last2, e.last2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick();
        chk("rst_valid", v1, 0);
        chk("rst_out", o1, 0);
        chk("rst_ch", ch1, 0);
        chk("rst_idx", idx1, 0);
        chk("rst_last", last1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_full", full1, 0);
        rst = 1'b0;
        tick();

        // single pixel, latency and throughput
        out_ready = 1'b1;
        strobe(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
        chk("lat_t0_valid", v1, 0);
        tick();
        chk("lat_t1_valid", v1, 1);
        chk("lat_t1_out", o1, 16'h0011);
        tick(); tick(); tick();
        chk("t4_out", o1, 16'h0044);
        chk("t4_last", last1, 1);
        tick();
        chk("idle_after", v1, 0);
        chk("single_queue", q.size(), 0);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        strobe(16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1);
        tick();
        chk("bp_valid", v1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out", o1, 16'h0011);
            chk("bp_ch", ch1, 0);
            chk("bp_idx", idx1, 0);
        end
        out_ready = 1'b1;
        wait_drain("bp_drain");

        // overflow with consumer stalled
        do_reset();
        out_ready = 1'b0;
        strobe(16'h0101, 16'h0102, 16'h0103, 16'h0104, 1'b1);
        strobe(16'h0201, 16'h0202, 16'h0203, 16'h0204, 1'b1);
        strobe(16'h0301, 16'h0302, 16'h0303, 16'h0304, 1'b1);
        chk("ovf_full3", full1, 0);
        strobe(16'h0401, 16'h0402, 16'h0403, 16'h0404, 1'b1);
        chk("ovf_full4", full1, 1);
        chk("ovf_full4_p2", full2, 1);
        chk("ovf_before", ovf1, 0);
        strobe(16'h0501, 16'h0502, 16'h0503, 16'h0504, 1'b0);
        chk("ovf_set", ovf1, OVF_EXP);
        chk("ovf_set_p2", ovf2, OVF_EXP);
        chk("ovf_full5", full1, 1);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        chk("ovf_sticky", ovf1, OVF_EXP);
        chk("ovf_full_after", full1, 0);

        // full FIFO with write on the ch=3 pop
        do_reset();
        out_ready = 1'b0;
        strobe(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 1'b1);
        strobe(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04, 1'b1);
        strobe(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04, 1'b1);
        strobe(16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 1'b1);
        chk("fp_full_before", full1, 1);
        out_ready = 1'b1;
        n = 0;
        while (ch1 != 2'd3 && n < 10) begin
            tick();
            n++;
        end
        chk("fp_reach_ch3", ch1, 3);
        strobe(16'h0E01, 16'h0E02, 16'h0E03, 16'h0E04, 1'b1);
        chk("fp_full_after", full1, 1);
        chk("fp_ovf", ovf1, 0);
        wait_drain("fp_drain");

        // frame wrap over three pixels
        do_reset();
        out_ready = 1'b1;
        strobe(16'h1001, 16'h1002, 16'h1003, 16'h1004, 1'b1);
        strobe(16'h2001, 16'h2002, 16'h2003, 16'h2004, 1'b1);
        strobe(16'h3001, 16'h3002, 16'h3003, 16'h3004, 1'b1);
        wait_drain("wrap_drain");

        // reset in the middle of the second pixel of a frame
        do_reset();
        out_ready = 1'b1;
        strobe(16'h4001, 16'h4002, 16'h4003, 16'h4004, 1'b1);
        strobe(16'h5001, 16'h5002, 16'h5003, 16'h5004, 1'b1);
        n = 0;
        while (!(v2 && idx2 == 8'd6) && n < 30) begin
            tick();
            n++;
        end
        chk("mid_idx", idx2, 6);
        chk("mid_ch", ch2, 2);
        rst = 1'b1;
        q.delete();
        pix2 = 0;
        #1;
        chk("mid_rst_valid", v1, 0);
        chk("mid_rst_out", o1, 0);
        chk("mid_rst_ch", ch1, 0);
        chk("mid_rst_idx", idx1, 0);
        chk("mid_rst_valid2", v2, 0);
        chk("mid_rst_idx2", idx2, 0);
        chk("mid_rst_last2", last2, 0);
        chk("mid_rst_full", full1, 0);
        tick();
        rst = 1'b0;
        tick();
        strobe(16'h6001, 16'h6002, 16'h6003, 16'h6004, 1'b1);
        tick();
        chk("post_rst_out", o2, 16'h6001);
        chk("post_rst_idx2", idx2, 0);
        wait_drain("post_rst_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flatten_4ch_serializer.md
# flatten_4ch_serializer

Downstream neighbour of the 4-channel 3x3 max-pool stage. It captures each 4-channel pooled pixel (`In_0..In_3` qualified by `valid_in`) into a small FIFO. It re-emits the values as a single serial stream, pixel-major then channel-minor, with a valid/ready handshake, a running flatten index and an end-of-frame flag. Its output feeds the fully-connected layer's input port.

## Interface
Parameters:
- `Datawidth`, 16, width of every data value
- `Depth`, 4, FIFO entries; each entry holds one 4-channel pixel; power of two, ≥2
- `Pixels`, 1, pooled pixels per frame; ≥1
- `IdxWidth`, 8, width of `out_idx`; must satisfy 2^IdxWidth ≥ 4·Pixels

Ports:
- `clk`, input, 1, sole clock; all state on rising edge
- `rst`, input, 1, asynchronous, active-high reset
- `valid_in`, input, 1, one-cycle strobe; `In_0..In_3` valid
- `In_0`..`In_3`, input, Datawidth each, channel 0..3 values of one pooled pixel
- `in_full`, output, 1, FIFO holds Depth entries
- `ovf`, output, 1, overflow flag (see Configuration)
- `out_valid`, output, 1, `Out` holds a value
- `out_ready`, input, 1, consumer accepts `Out` this cycle
- `Out`, output, Datawidth, serial data value
- `out_ch`, output, 2, channel of `Out` (0..3)
- `out_idx`, output, IdxWidth, flatten index = pixel·4 + channel
- `out_last`, output, 1, high with the final value of a frame (pixel Pixels-1, channel 3)

## Operation
- Storage is a FIFO of Depth × (4·Datawidth) with wr/rd pointers of log2(Depth) bits that wrap at Depth-1→0, plus a count of log2(Depth)+1 bits.
- Write: when `valid_in`=1 and (count<Depth, or the head entry is popped this same cycle), {In_3,In_2,In_1,In_0} is written at wr_ptr, then wr_ptr advances.
- A write when full with no same-cycle pop is dropped and leaves the FIFO unchanged.
- The serializer FSM has two states, IDLE and SEND, with a channel counter `ch` (2 b) and a pixel counter `pix` (0..Pixels-1).
- IDLE: `out_valid`=0. When count>0 (FIFO state as of the current cycle), go to SEND with `Out`=head[ch=0].
- SEND: `out_valid`=1 and `Out`, `out_ch`, `out_idx`, `out_last` are held stable until `out_ready`=1. On each handshake:
  - ch<3: ch+1, and `Out` is reloaded from the head entry.
  - ch=3: pop the head (rd_ptr+1, count-1) and set ch to 0. Set pix to pix+1, wrapping to 0 after Pixels-1.
  - After the ch=3 handshake, stay in SEND with the next head if count after pop >0; otherwise go to IDLE.
- `out_idx` = pix·4 + ch, truncated to IdxWidth.
- `out_last` = (pix==Pixels-1) && (ch==3) while in SEND.
- Simultaneous write and pop: count is unchanged and both pointers advance.
- Reset (`rst`=1 at any time, including mid-frame): pointers, count, ch, pix and FSM go to IDLE/0, and all FIFO contents are discarded.
- Reset values: `out_valid`=0, `Out`=0, `out_ch`=0, `out_idx`=0, `out_last`=0, `ovf`=0, `in_full`=0.

## Timing
- Latency: a `valid_in` at edge t into an empty FIFO with FSM in IDLE gives `out_valid`=1 with channel 0 after edge t+1.
- Throughput: one value per cycle while `out_ready`=1, i.e. 4 cycles per pixel.
- The upstream pool strobes at most one pixel per stride, so Depth=4 absorbs the gaps.
- `in_full` is registered from count and reflects the state after the current edge.
- All outputs are registered, with no combinational path from `out_ready` to `Out` or `out_valid`.
- `out_ready` while `out_valid`=0 is ignored.

## Configuration
- Macro: `FLATTEN4_OVERFLOW_FLAG_EN`.
- Defined: a dropped write sets `ovf`=1 one cycle later. `ovf` is sticky and cleared only by `rst`.
- Not defined: `ovf` is tied to 0 and dropped writes are silent. Data-path behaviour is otherwise identical.

## Test plan
- Single pixel, Pixels=1: `rst`, then `valid_in` with In_0..3 = 0x0011, 0x0022, 0x0033, 0x0044 and `out_ready`=1 → over 4 consecutive cycles from t+1, `Out` = 0x0011, 0x0022, 0x0033, 0x0044; `out_idx` = 0..3; `out_last` high only on 0x0044; then `out_valid`=0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` rises → `Out`=0x0011, `out_ch`=0 and `out_idx`=0 stay stable; on release the remaining order is unchanged.
- Overflow, macro defined, `out_ready`=0: 5 strobes → `in_full`=1 after the 4th strobe and `ovf`=1 after the 5th. Draining then yields exactly the first 4 pixels in order.
- Full plus simultaneous pop: FIFO full, `valid_in` in the same cycle as the ch=3 handshake → write is accepted, `ovf` stays 0 and `in_full` stays 1.
- Frame wrap, Pixels=2: 3 pixels → `out_idx` runs 0..7 with `out_last` at idx 7, then restarts at 0 for the 3rd pixel.
- Reset mid-frame: assert `rst` while `out_ch`=2 → all outputs go to 0 immediately (async). The next pixel after release starts at `out_idx`=0.
